// File: rtl/ptlut_reader.sv
// ptlut_reader: requester side of the pT LUT interface.
// Once per BX it reads up to three pT LUT addresses serially from external
// memory over a req/gnt + rvalid handshake. It then presents the three pT
// words, with per-track timeout flags, as one aligned bundle with a one-cycle
// strobe.
module ptlut_reader #(
  parameter int ADDR_BW = 30,
  parameter int DATA_BW = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3*ADDR_BW-1:0]   ptlut_addr,
  input  logic [2:0]             trk_valid,
  output logic                   mem_req,
  output logic [ADDR_BW-1:0]     mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [DATA_BW-1:0]     mem_rdata,
  output logic [3*DATA_BW-1:0]   pt,
  output logic                   pt_valid,
  output logic [2:0]             pt_tmo,
  output logic                   busy,
  output logic                   overrun
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_V = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [3*ADDR_BW-1:0]   addr_q, addr_d;
  logic [2:0]             tv_q, tv_d;
  logic [3*DATA_BW-1:0]   sh_pt_q, sh_pt_d;
  logic [2:0]             sh_tmo_q, sh_tmo_d;
  logic                   adv_s;

  logic                   mem_req_q, mem_req_d;
  logic [ADDR_BW-1:0]     mem_addr_q, mem_addr_d;
  logic [3*DATA_BW-1:0]   pt_q, pt_d;
  logic                   pt_valid_q, pt_valid_d;
  logic [2:0]             pt_tmo_q, pt_tmo_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  // Next-state logic for the read sequencer and its registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    tv_d       = tv_q;
    sh_pt_d    = sh_pt_q;
    sh_tmo_d   = sh_tmo_q;
    adv_s      = 1'b0;
    pt_d       = pt_q;
    pt_tmo_d   = pt_tmo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = ptlut_addr;
          tv_d     = trk_valid;
          sh_pt_d  = '0;
          sh_tmo_d = 3'b000;
          idx_d    = 2'd0;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        if (!tv_q[idx_q]) begin
          // No track in this slot: result is zero and no memory access.
          sh_pt_d[idx_q*DATA_BW +: DATA_BW] = '0;
          adv_s = 1'b1;
        end else if (mem_gnt) begin
          state_d = WAIT;
          timer_d = '0;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        // rvalid is checked first so it wins over a simultaneous timeout.
        if (mem_rvalid) begin
          sh_pt_d[idx_q*DATA_BW +: DATA_BW] = mem_rdata;
          adv_s = 1'b1;
        end else if (timer_q == TMO_V) begin
          sh_pt_d[idx_q*DATA_BW +: DATA_BW] = '0;
          sh_tmo_d[idx_q] = 1'b1;
          adv_s = 1'b1;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (adv_s) begin
      if (idx_q == 2'd2) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = ISSUE;
      end
    end else begin
      idx_d = idx_d;
    end

    // Outputs are computed from the next state so they are registered yet
    // aligned with the state they belong to.
    mem_req_d = (state_d == ISSUE) && tv_d[idx_d];
    if (mem_req_d) begin
      mem_addr_d = addr_d[idx_d*ADDR_BW +: ADDR_BW];
    end else begin
      mem_addr_d = '0;
    end

    pt_valid_d = (state_d == DONE);
    if (state_d == DONE) begin
      pt_d     = sh_pt_d;
      pt_tmo_d = sh_tmo_d;
    end else begin
      pt_d     = pt_q;
      pt_tmo_d = pt_tmo_q;
    end

    busy_d    = (state_d != IDLE);
    overrun_d = start && (state_q != IDLE);
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      timer_q    <= '0;
      addr_q     <= '0;
      tv_q       <= 3'b000;
      sh_pt_q    <= '0;
      sh_tmo_q   <= 3'b000;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
      pt_tmo_q   <= 3'b000;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      tv_q       <= tv_d;
      sh_pt_q    <= sh_pt_d;
      sh_tmo_q   <= sh_tmo_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pt_q       <= pt_d;
      pt_valid_q <= pt_valid_d;
      pt_tmo_q   <= pt_tmo_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pt       = pt_q;
  assign pt_valid = pt_valid_q;
  assign pt_tmo   = pt_tmo_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_ptlut_reader.sv
// Directed testbench for ptlut_reader with a small behavioural LUT memory.
module tb_ptlut_reader;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [89:0]   ptlut_addr = '0;
  logic [2:0]    trk_valid = 3'b000;
  logic          mem_req;
  logic [29:0]   mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [8:0]    mem_rdata = 9'h000;
  logic [26:0]   pt;
  logic          pt_valid;
  logic [2:0]    pt_tmo;
  logic          busy;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;

  // memory model configuration
  logic [29:0] addr_tab [4];
  logic [8:0]  data_tab [4];
  int          gnt_wait [4];
  int          drop_trk = -1;
  bit          late_rv  = 1'b0;
  logic [29:0] gaddr [$];

  // monitor counters
  int pv_cnt = 0;
  int ov_cnt = 0;
  int req_cyc = 0;

  ptlut_reader #(.ADDR_BW(30), .DATA_BW(9), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .ptlut_addr(ptlut_addr),
    .trk_valid(trk_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pt(pt), .pt_valid(pt_valid), .pt_tmo(pt_tmo), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int trk_of(input logic [29:0] a);
    for (int i = 0; i < 3; i++) if (addr_tab[i] == a) return i;
    return 3;
  endfunction

  // output monitor
  initial begin
    forever begin
      @(negedge clk);
      if (pt_valid) pv_cnt++;
      if (overrun) ov_cnt++;
      if (mem_req) req_cyc++;
    end
  end

  // LUT memory responder: gnt after gnt_wait cycles, rvalid one cycle later
  initial begin
    int gcnt = 0;
    bit pending = 1'b0;
    int ptrk = 0;
    bit hold_seen = 1'b0;
    logic [29:0] hold_addr = '0;
    int t;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = 9'h000;
      if (rst) begin
        pending = 1'b0; gcnt = 0; hold_seen = 1'b0;
      end else if (mem_req) begin
        if (!hold_seen) begin
          hold_addr = mem_addr; hold_seen = 1'b1;
        end else begin
          check_val("addr_stable", mem_addr, hold_addr);
        end
        t = trk_of(mem_addr);
        if (late_rv && t == 2) begin
          mem_rvalid = 1'b1; mem_rdata = 9'h1AB;
        end
        if (gcnt >= gnt_wait[t]) begin
          mem_gnt = 1'b1; gcnt = 0; pending = 1'b1; ptrk = t;
          gaddr.push_back(mem_addr); hold_seen = 1'b0;
        end else begin
          gcnt++;
        end
      end else if (pending) begin
        pending = 1'b0;
        if (ptrk != drop_trk) begin
          mem_rvalid = 1'b1; mem_rdata = data_tab[ptrk];
        end
      end
    end
  end

  task automatic do_set(input string tag, input logic [2:0] tv, input int exp_lat,
                        input logic [26:0] exp_pt, input logic [2:0] exp_tmo,
                        input int exp_req, input int ovr_at);
    int n;
    int pv0;
    int rq0;
    int ov0;
    gaddr.delete();
    @(negedge clk);
    pv0 = pv_cnt; rq0 = req_cyc; ov0 = ov_cnt;
    ptlut_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};
    trk_valid = tv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!pt_valid && n < 200) begin
      if (n == ovr_at) begin
        start = 1'b1; ptlut_addr = ~ptlut_addr; trk_valid = 3'b111;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_pt"}, pt, exp_pt);
    check_val({tag, "_tmo"}, pt_tmo, exp_tmo);
    repeat (4) @(negedge clk);
    #1;
    check_val({tag, "_npv"}, pv_cnt - pv0, 1);
    check_val({tag, "_nreq"}, req_cyc - rq0, exp_req);
    check_val({tag, "_novr"}, ov_cnt - ov0, (ovr_at > 0) ? 1 : 0);
    check_val({tag, "_pt_hold"}, pt, exp_pt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    addr_tab[0] = 30'h0ABCDE01; addr_tab[1] = 30'h12345678;
    addr_tab[2] = 30'h2FEDCBA9; addr_tab[3] = 30'h00000000;
    data_tab[0] = 9'h011; data_tab[1] = 9'h022; data_tab[2] = 9'h033; data_tab[3] = 9'h000;
    for (int i = 0; i < 4; i++) gnt_wait[i] = 0;

    repeat (3) @(negedge clk);
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_mem_addr", mem_addr, 30'h0);
    check_val("rst_pt", pt, 27'h0);
    check_val("rst_pt_valid", pt_valid, 1'b0);
    check_val("rst_pt_tmo", pt_tmo, 3'b000);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    // 1: all tracks valid, immediate gnt, rvalid next cycle
    do_set("t1", 3'b111, 7, {9'h033, 9'h022, 9'h011}, 3'b000, 3, 0);
    check_val("t1_ngnt", gaddr.size(), 3);
    if (gaddr.size() == 3) begin
      check_val("t1_addr0", gaddr[0], addr_tab[0]);
      check_val("t1_addr1", gaddr[1], addr_tab[1]);
      check_val("t1_addr2", gaddr[2], addr_tab[2]);
    end

    // 2: only track 1 valid
    data_tab[1] = 9'h1FF;
    do_set("t2", 3'b010, 5, {9'h000, 9'h1FF, 9'h000}, 3'b000, 1, 0);
    check_val("t2_addr", (gaddr.size() == 1) ? gaddr[0] : 30'h0, addr_tab[1]);
    data_tab[1] = 9'h022;

    // all tracks invalid
    do_set("t0v", 3'b000, 4, 27'h0, 3'b000, 0, 0);

    // 3: gnt held off 4 cycles on track 0
    gnt_wait[0] = 4;
    do_set("t3", 3'b111, 11, {9'h033, 9'h022, 9'h011}, 3'b000, 7, 0);
    gnt_wait[0] = 0;

    // 4: track 1 times out, late rvalid during track 2 ISSUE
    drop_trk = 1; late_rv = 1'b1;
    do_set("t4", 3'b111, 22, {9'h033, 9'h000, 9'h011}, 3'b010, 3, 0);
    drop_trk = -1; late_rv = 1'b0;

    // 5: second start while busy
    do_set("t5", 3'b111, 7, {9'h033, 9'h022, 9'h011}, 3'b000, 3, 2);

    // 6: reset during WAIT of track 1
    @(negedge clk);
    n = pv_cnt;
    ptlut_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};
    trk_valid = 3'b111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !(mem_req && mem_addr == addr_tab[1]); k++) @(negedge clk);
    check_val("t6_reach_trk1", mem_req && (mem_addr == addr_tab[1]), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_mem_req", mem_req, 1'b0);
    check_val("t6_busy", busy, 1'b0);
    check_val("t6_pt_valid", pt_valid, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_val("t6_no_pv", pv_cnt - n, 0);
    do_set("t6b", 3'b111, 7, {9'h033, 9'h022, 9'h011}, 3'b000, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
